edge_stream_seq: RTL
====================

Name: edge_stream_seq

Overview:
- Synthesizable stimulus sequencer that feeds the edge-detection filter core.
- On `start` it emits a KSIZE×KSIZE coefficient set on `fc`/`fc_valid`.
- It then reads RGB pixels from a frame memory, converts each to gray, and streams them to the filter over a valid/ready handshake.
- It counts filter output pulses and signals `done` after IMG_W*IMG_H results.
- It replaces the behavioural image/coefficient driver in hardware builds and generalises kernel size, image size and coefficient mode.

Parameters:
- IMG_W, 256, pixels per row (≥2).
- IMG_H, 256, rows per frame (≥1).
- KSIZE, 5, kernel edge length; odd, 3..7.
- PIX_W, 8, gray pixel width.
- ADDR_W, 16, memory address width; must satisfy 2^ADDR_W ≥ IMG_W*IMG_H.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  frame start request, sampled only in IDLE.
- mode  in  1  coefficient mode, latched on start: 0 = Laplacian, 1 = identity.
- busy  out  1  high in every state except IDLE.
- fc_valid  out  1  coefficient strobe.
- fc  out  8  signed coefficient, two's complement.
- mem_rd  out  1  frame memory read enable.
- mem_addr  out  ADDR_W  read address, row-major, address 0 = pixel [0][0].
- mem_rdata  in  24  {R[23:16], G[15:8], B[7:0]}; valid exactly 1 cycle after `mem_rd`.
- pix_valid  out  1  gray pixel available.
- pix_ready  in  1  filter accepts pixel.
- pix_data  out  PIX_W  gray pixel.
- out_valid  in  1  one-cycle pulse per filter result.
- out_count  out  clog2(IMG_W*IMG_H+1)  results counted this frame.
- done  out  1  one-cycle frame-complete pulse.

Behaviour:
- Reset: all outputs 0 (busy, fc_valid, fc, mem_rd, mem_addr, pix_valid, pix_data, out_count, done). FSM → IDLE. Internal buffer is emptied and any in-flight read is discarded. A reset asserted in any state takes effect at the next clock edge.
- FSM states: IDLE → COEFF → PIXEL → DRAIN → FIN → IDLE.
- IDLE:
  - start=1 at edge N: latch `mode`, clear `out_count`, and enter COEFF at N+1.
  - start in any other state is ignored.
  - out_valid in IDLE is ignored.
- COEFF:
  - fc_valid=1 for exactly KSIZE*KSIZE consecutive cycles. Index k runs 0..K*K-1, row-major.
  - Centre index is (K*K-1)/2.
  - mode 0: centre coefficient = K*K-1 (24 for K=5, 8 for K=3), all others = -1 (8'hFF).
  - mode 1: centre coefficient = 1, all others = 0.
  - After the last coefficient cycle, fc_valid=0 and fc=0; the FSM enters PIXEL.
- PIXEL:
  - Addresses are issued 0..IMG_W*IMG_H-1 in order, with no skips and no repeats.
  - A 2-entry FIFO sits between the memory return and the pix_* outputs.
  - mem_rd is asserted only when (FIFO occupancy + reads in flight) < 2. Pixels are never dropped under any pix_ready pattern.
  - Sustained throughput is 1 pixel/cycle while pix_ready=1.
  - Gray conversion: 10-bit sum R+G+B, integer divide by 3 with truncation. Result is placed in the low 8 bits; for PIX_W>8 it is zero-extended at the MSB side.
  - Handshake: a transfer occurs on a cycle with pix_valid & pix_ready. While pix_valid=1 and pix_ready=0, pix_data is held stable. pix_valid never drops without a transfer.
  - When the last pixel transfers, the FSM enters DRAIN.
- Output counting: each out_valid in PIXEL or DRAIN increments out_count. out_count saturates at IMG_W*IMG_H; extra pulses are ignored.
- DRAIN: when out_count == IMG_W*IMG_H (including increments in the same cycle), the FSM enters FIN.
- FIN: done=1 for exactly one cycle, then IDLE. out_count holds its final value until the next start.
- busy: 1 in COEFF, PIXEL, DRAIN and FIN.

Test Plan:
- Reset: hold rst_n=0 for 3 clocks with start=1 → all outputs 0 and busy=0. After release, first fc_valid appears 1 cycle after the first start sample.
- Coefficients, KSIZE=5, mode 0: start → 25 consecutive fc_valid cycles; fc[12]=24 and the other 24 values are 8'hFF. Then fc_valid=0 and the first mem_rd follows in the next cycle.
- Coefficients, KSIZE=3, mode 1: start → 9 cycles; fc = 0,0,0,0,1,0,0,0,0.
- Gray conversion, IMG_W=4, IMG_H=2, pix_ready=1, memory words FF0000, FFFFFF, 010101, 020100, 000000, 808080, 0000FF, 7F7F80 → pix_data 85, 255, 1, 1, 0, 128, 85, 127, delivered on 8 consecutive cycles.
- Backpressure: pix_ready=0 for 10 cycles mid-frame, then toggling 1/0 → pix_data stable while stalled; mem_rd stops once FIFO + in-flight reaches 2; all 8 pixels delivered in address order with no duplicates.
- Completion and robustness:
  - 8 out_valid pulses → done high for 1 cycle with out_count=8. A 9th pulse leaves out_count at 8.
  - start during PIXEL has no effect.
  - rst_n=0 mid-PIXEL → IDLE next clock with all outputs 0. A subsequent start reruns cleanly from address 0.

Source files
------------

// File: rtl/edge_stream_seq.sv
// rtl/edge_stream_seq.sv - coefficient and gray-pixel stimulus sequencer for the edge filter core
module edge_stream_seq #(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int KSIZE  = 5,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 16,
    localparam int NPIX  = IMG_W * IMG_H,
    localparam int CNT_W = $clog2(NPIX + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    output logic              busy,
    output logic              fc_valid,
    output logic [7:0]        fc,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [23:0]       mem_rdata,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [PIX_W-1:0]  pix_data,
    input  logic              out_valid,
    output logic [CNT_W-1:0]  out_count,
    output logic              done
);
    localparam int KK     = KSIZE * KSIZE;
    localparam int K_W    = $clog2(KK);
    localparam int CENTER = (KK - 1) / 2;

    typedef enum logic [2:0] {S_IDLE, S_COEFF, S_PIXEL, S_DRAIN, S_FIN} state_t;

    state_t             state, state_nx;
    logic [K_W-1:0]     k_idx;
    logic               mode_q;
    logic [CNT_W-1:0]   issued, sent, out_cnt_q, out_cnt_nx;
    logic               in_flight;
    logic [1:0]         fifo_cnt, occupancy;
    logic [PIX_W-1:0]   buf0, buf1, gray_pix;
    logic [ADDR_W-1:0]  addr_q;
    logic [9:0]         rgb_sum;
    logic [7:0]         gray8;
    logic               xfer, push, pop, cnt_inc, start_ok;

    assign rgb_sum  = {2'b00, mem_rdata[23:16]} + {2'b00, mem_rdata[15:8]} + {2'b00, mem_rdata[7:0]};
    assign gray8    = 8'(rgb_sum / 10'd3);
    assign gray_pix = PIX_W'(gray8);

    // Memory data is presented directly while the FIFO is empty, so a read
    // issued every cycle keeps one pixel per cycle flowing without a third slot.
    assign occupancy = fifo_cnt + {1'b0, in_flight};
    assign mem_rd    = (state == S_PIXEL) && (issued != CNT_W'(NPIX)) && (occupancy < 2'd2);
    assign mem_addr  = addr_q;
    assign pix_valid = (state == S_PIXEL) && ((fifo_cnt != 2'd0) || in_flight);
    assign pix_data  = (fifo_cnt != 2'd0) ? buf0 : (in_flight ? gray_pix : '0);
    assign xfer      = pix_valid && pix_ready;
    assign pop       = (fifo_cnt != 2'd0) && xfer;
    assign push      = in_flight && !((fifo_cnt == 2'd0) && pix_ready);
    assign start_ok  = (state == S_IDLE) && start;

    assign cnt_inc    = ((state == S_PIXEL) || (state == S_DRAIN)) && out_valid
                        && (out_cnt_q != CNT_W'(NPIX));
    assign out_cnt_nx = out_cnt_q + CNT_W'(cnt_inc);
    assign out_count  = out_cnt_q;

    always_comb begin
        state_nx = state;
        busy     = 1'b1;
        fc_valid = 1'b0;
        fc       = 8'd0;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nx = S_COEFF;
            end
            S_COEFF: begin
                fc_valid = 1'b1;
                if (k_idx == K_W'(CENTER)) fc = mode_q ? 8'd1 : 8'(KK - 1);
                else                       fc = mode_q ? 8'd0 : 8'hFF;
                if (k_idx == K_W'(KK - 1)) state_nx = S_PIXEL;
            end
            S_PIXEL: begin
                if (xfer && (sent == CNT_W'(NPIX - 1))) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                if (out_cnt_nx == CNT_W'(NPIX)) state_nx = S_FIN;
            end
            S_FIN: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            k_idx     <= '0;
            mode_q    <= 1'b0;
            issued    <= '0;
            sent      <= '0;
            out_cnt_q <= '0;
            in_flight <= 1'b0;
            fifo_cnt  <= 2'd0;
            buf0      <= '0;
            buf1      <= '0;
            addr_q    <= '0;
        end else begin
            state     <= state_nx;
            in_flight <= mem_rd;
            out_cnt_q <= out_cnt_nx;
            if (state == S_COEFF) k_idx <= k_idx + K_W'(1);
            if (mem_rd) begin
                issued <= issued + CNT_W'(1);
                addr_q <= addr_q + ADDR_W'(1);
            end
            if (xfer) sent <= sent + CNT_W'(1);
            case ({pop, push})
                2'b10: begin
                    buf0     <= buf1;
                    fifo_cnt <= fifo_cnt - 2'd1;
                end
                2'b01: begin
                    if (fifo_cnt == 2'd0) buf0 <= gray_pix;
                    else                  buf1 <= gray_pix;
                    fifo_cnt <= fifo_cnt + 2'd1;
                end
                2'b11: begin
                    if (fifo_cnt == 2'd1) begin
                        buf0 <= gray_pix;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= gray_pix;
                    end
                end
                default: ;
            endcase
            if (start_ok) begin
                mode_q    <= mode;
                k_idx     <= '0;
                issued    <= '0;
                sent      <= '0;
                out_cnt_q <= '0;
                addr_q    <= '0;
                fifo_cnt  <= 2'd0;
                in_flight <= 1'b0;
            end
        end
    end
endmodule
